// File: rtl/spike_encoder.sv
// Value-to-time spike encoder: owns the gamma phase counter and turns one token
// per gamma cycle into a pulse whose rising edge sits at phase == value.
module spike_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_null,
  output logic [VAL_W-1:0] phase,
  output logic             gamma_start,
  output logic             y
);

  // Two spare bits keep value + PULSE_WIDTH from wrapping.
  localparam int AW = VAL_W + 2;

  localparam logic [VAL_W-1:0] PHASE_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [AW-1:0]    GAMMA_A    = AW'(GAMMA_CYCLE_WIDTH);
  localparam logic [AW-1:0]    PW_A       = AW'(PULSE_WIDTH);

  typedef struct packed {
    logic             is_null;
    logic [VAL_W-1:0] value;
  } token_t;

  localparam token_t NULL_TOKEN = '{is_null: 1'b1, value: '0};

  logic [VAL_W-1:0] phase_q, phase_d;
  logic             gamma_start_q, gamma_start_d;
  logic             pending_valid_q, pending_valid_d;
  token_t           pending_q, pending_d;
  token_t           active_q, active_d;
  logic             y_q, y_d;

  logic             boundary;
  logic             transfer;
  logic [AW-1:0]    phase_ext;
  logic [AW-1:0]    value_ext;

  assign in_ready = !pending_valid_q && !grst;
  assign transfer = in_valid && in_ready;

  // Explicit wrap rather than a modulo so non-power-of-2 gamma lengths count correctly.
  always_comb begin
    boundary      = (phase_q == PHASE_LAST);
    phase_d       = boundary ? '0 : phase_q + VAL_W'(1);
    gamma_start_d = (phase_d == '0);
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_d       = pending_q;
    active_d        = active_q;
    if (boundary) begin
      active_d        = pending_valid_q ? pending_q : NULL_TOKEN;
      pending_valid_d = 1'b0;
    end
    // A transfer in the last phase lands after the commit, so it waits one extra gamma.
    if (transfer) begin
      pending_valid_d = 1'b1;
      pending_d       = '{is_null: in_null, value: in_value};
    end
  end

  // Spike decoded from next-state values so y lines up with the phase output.
  always_comb begin
    phase_ext = AW'(phase_d);
    value_ext = AW'(active_d.value);
    y_d = !active_d.is_null
          && (value_ext < GAMMA_A)
          && (phase_ext >= value_ext)
          && (phase_ext < value_ext + PW_A);
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (grst) begin
      phase_q         <= PHASE_LAST;
      gamma_start_q   <= 1'b0;
      pending_valid_q <= 1'b0;
      pending_q       <= NULL_TOKEN;
      active_q        <= NULL_TOKEN;
      y_q             <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      gamma_start_q   <= gamma_start_d;
      pending_valid_q <= pending_valid_d;
      pending_q       <= pending_d;
      active_q        <= active_d;
      y_q             <= y_d;
    end
  end

  assign phase       = phase_q;
  assign gamma_start = gamma_start_q;
  assign y           = y_q;

endmodule
